// File: rtl/shift_reg_flow.sv
// -----------------------------------------------------------------------------
// shift_reg_flow
//   Valid-qualified delay line with a run-time selectable depth, a shared stall
//   (en_i) and a synchronous flush. It retimes side-band beats by depth_o
//   cycles of en_i=1. The depth is changed through a cfg handshake that is
//   only accepted while the line is stalled, not flushing and empty.
//
//   Optional feature: define SHIFT_REG_FLOW_CNT_EN to build the occupancy
//   counter behind cnt_o. Without it, cnt_o is tied to 0.
//
// Parameters
//   DataWidth   payload width in bits (>=1)
//   MaxDepth    number of physical stages (>=1), largest selectable delay
//   ResetDepth  delay after reset, 0..MaxDepth
//   DepthW      derived width of depth/count values; do not override
//
// Ports
//   clk_i        clock
//   rst_ni       asynchronous active-low reset
//   en_i         1 = advance one stage, 0 = hold all state
//   flush_i      clears every in-flight valid on the next edge; wins over en_i
//   valid_i/d_i  input beat, sampled only when en_i=1
//   valid_o/d_o  output beat (combinational pass-through when depth is 0)
//   cfg_valid_i  depth update request
//   cfg_depth_i  requested delay, saturated to MaxDepth
//   cfg_ready_o  depth update accepted this cycle
//   depth_o      active delay
//   cnt_o        beats in flight (0 unless SHIFT_REG_FLOW_CNT_EN)
// -----------------------------------------------------------------------------
module shift_reg_flow #(
    parameter int DataWidth  = 32,
    parameter int MaxDepth   = 8,
    parameter int ResetDepth = 1,
    parameter int DepthW     = $clog2(MaxDepth + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 en_i,
    input  logic                 flush_i,
    input  logic                 valid_i,
    input  logic [DataWidth-1:0] d_i,
    output logic                 valid_o,
    output logic [DataWidth-1:0] d_o,
    input  logic                 cfg_valid_i,
    input  logic [DepthW-1:0]    cfg_depth_i,
    output logic                 cfg_ready_o,
    output logic [DepthW-1:0]    depth_o,
    output logic [DepthW-1:0]    cnt_o
);

    logic [DepthW-1:0]    depth_reg;
    logic                 stage_v [MaxDepth];
    logic [DataWidth-1:0] stage_d [MaxDepth];
    logic                 any_valid;
    logic                 sel_valid;
    logic [DataWidth-1:0] sel_data;
    logic                 cfg_accept;
    logic [DepthW-1:0]    cfg_depth_sat;

    // ------------------------------------------------------------------
    // Stage chain. Each stage takes its source from the previous stage
    // (or from the input for stage 0). Stages at or beyond the active
    // depth shift in a 0 valid, so nothing lingers in them once the depth
    // is reduced. Data only moves along with a valid beat; a bubble leaves
    // the data behind it untouched.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < MaxDepth; gi++) begin : g_stage
        logic                 src_v;
        logic [DataWidth-1:0] src_d;
        logic                 active;
        logic                 v_reg, v_next;
        logic [DataWidth-1:0] d_reg, d_next;

        if (gi == 0) begin : g_head
            assign src_v = valid_i;
            assign src_d = d_i;
        end else begin : g_body
            assign src_v = stage_v[gi-1];
            assign src_d = stage_d[gi-1];
        end

        assign active = (DepthW'(gi) < depth_reg);

        always_comb begin
            v_next = v_reg;
            d_next = d_reg;
            if (flush_i) begin
                // Flush clears valids only; stale data is harmless.
                v_next = 1'b0;
            end else if (en_i) begin
                v_next = src_v & active;
                if (src_v) begin
                    d_next = src_d;
                end
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                v_reg <= 1'b0;
                d_reg <= '0;
            end else begin
                v_reg <= v_next;
                d_reg <= d_next;
            end
        end

        assign stage_v[gi] = v_reg;
        assign stage_d[gi] = d_reg;
    end

    // Output tap: stage depth_reg-1, selected by comparison so the index
    // width never has to match the array size.
    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        any_valid = 1'b0;
        for (int k = 0; k < MaxDepth; k++) begin
            any_valid = any_valid | stage_v[k];
            if (depth_reg == DepthW'(k + 1)) begin
                sel_valid = stage_v[k];
                sel_data  = stage_d[k];
            end
        end
    end

    always_comb begin
        if (depth_reg == '0) begin
            valid_o = valid_i & en_i;
            d_o     = d_i;
        end else begin
            valid_o = sel_valid;
            d_o     = sel_data;
        end
    end

    // ------------------------------------------------------------------
    // Depth configuration. Ready only while stalled and empty, so a
    // depth change can never strand or reorder an in-flight beat.
    // ------------------------------------------------------------------
    assign cfg_ready_o   = ~en_i & ~flush_i & ~any_valid;
    assign cfg_accept    = cfg_valid_i & cfg_ready_o;
    assign cfg_depth_sat = (cfg_depth_i > DepthW'(MaxDepth)) ? DepthW'(MaxDepth)
                                                             : cfg_depth_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            depth_reg <= DepthW'(ResetDepth);
        end else if (cfg_accept) begin
            depth_reg <= cfg_depth_sat;
        end
    end

    assign depth_o = depth_reg;

`ifdef SHIFT_REG_FLOW_CNT_EN
    // Occupancy: +1 when a beat enters an active stage, -1 when the output
    // beat leaves on an advancing edge. Pass-through mode holds nothing.
    logic              cnt_enter;
    logic [DepthW-1:0] cnt_reg, cnt_next;

    assign cnt_enter = valid_i & (depth_reg != '0);

    always_comb begin
        cnt_next = cnt_reg;
        if (flush_i) begin
            cnt_next = '0;
        end else if (en_i) begin
            if (depth_reg == '0) begin
                cnt_next = '0;
            end else begin
                cnt_next = cnt_reg + DepthW'(cnt_enter) - DepthW'(valid_o);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign cnt_o = cnt_reg;
`else
    assign cnt_o = '0;
`endif

endmodule

// File: tb/tb_shift_reg_flow.sv
// -----------------------------------------------------------------------------
// tb_shift_reg_flow
//   Scoreboard bench for shift_reg_flow. The stimulus process pushes every
//   accepted beat with the advance-cycle index at which it must be presented
//   (entry index + depth). The monitor process, on every falling edge,
//   compares valid_o/d_o against the queue head, and also checks depth_o,
//   cfg_ready_o and cnt_o against the model's view of what is in flight.
// -----------------------------------------------------------------------------
module tb_shift_reg_flow;
    localparam int DW   = 16;
    localparam int MD   = 8;
    localparam int RD   = 3;
    localparam int DEPW = $clog2(MD + 1);

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b0;
    logic            en_i = 1'b0;
    logic            flush_i = 1'b0;
    logic            valid_i = 1'b0;
    logic [DW-1:0]   d_i = '0;
    logic            valid_o;
    logic [DW-1:0]   d_o;
    logic            cfg_valid_i = 1'b0;
    logic [DEPW-1:0] cfg_depth_i = '0;
    logic            cfg_ready_o;
    logic [DEPW-1:0] depth_o;
    logic [DEPW-1:0] cnt_o;

    shift_reg_flow #(
        .DataWidth (DW),
        .MaxDepth  (MD),
        .ResetDepth(RD)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .en_i       (en_i),
        .flush_i    (flush_i),
        .valid_i    (valid_i),
        .d_i        (d_i),
        .valid_o    (valid_o),
        .d_o        (d_o),
        .cfg_valid_i(cfg_valid_i),
        .cfg_depth_i(cfg_depth_i),
        .cfg_ready_o(cfg_ready_o),
        .depth_o    (depth_o),
        .cnt_o      (cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [DW-1:0] data;
        int            due;   // advance index at which the beat is presented
        int            ent;   // advance index of the entry edge
    } beat_t;

    beat_t exp_q[$];
    int    cur_n      = 0;   // advance edges completed before the current cycle
    int    en_count   = 0;
    int    exp_depth  = RD;
    int    pend_depth = -1;
    int    n_checks   = 0;
    int    n_fail     = 0;

    function automatic void check(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // One clock of stimulus; inputs change 1 time unit after the rising edge.
    task automatic drive(input bit en, input bit fl, input bit v,
                         input logic [DW-1:0] d, input bit cv, input int cd);
        @(posedge clk_i);
        #1;
        if (pend_depth >= 0) begin
            exp_depth  = pend_depth;
            pend_depth = -1;
        end
        if (exp_depth == 0) fl = 1'b0;   // flush is not exercised in pass-through
        en_i        = en;
        flush_i     = fl;
        valid_i     = v;
        d_i         = d;
        cfg_valid_i = cv;
        cfg_depth_i = DEPW'(cd);
        cur_n       = en_count;
        if (v && en && !fl) exp_q.push_back('{d, cur_n + exp_depth, cur_n});
        if (cv && !en && !fl && exp_q.size() == 0) pend_depth = (cd > MD) ? MD : cd;
        if (en && !fl) en_count++;
    endtask

    task automatic bubbles(input int n);
        for (int i = 0; i < n; i++) drive(1, 0, 0, '0, 0, 0);
    endtask

    task automatic set_depth(input int cd);
        drive(0, 0, 0, '0, 1, cd);
    endtask

    task automatic do_reset();
        @(posedge clk_i);
        #1;
        rst_ni      = 1'b0;
        en_i        = 1'b0;
        flush_i     = 1'b0;
        valid_i     = 1'b0;
        cfg_valid_i = 1'b0;
        exp_q.delete();
        exp_depth  = RD;
        pend_depth = -1;
        cur_n      = en_count;
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    // Monitor / scoreboard
    initial begin
        forever begin
            @(negedge clk_i);
            begin
                bit exp_v;
                int inflight;
                int exp_cnt;
                exp_v    = (exp_q.size() > 0) && (exp_q[0].due == cur_n);
                inflight = 0;
                foreach (exp_q[i]) if (exp_q[i].ent < cur_n) inflight++;
`ifdef SHIFT_REG_FLOW_CNT_EN
                exp_cnt = (exp_depth == 0) ? 0 : inflight;
`else
                exp_cnt = 0;
`endif
                check("valid_o", int'(valid_o), int'(exp_v));
                if (exp_v) check("d_o", int'(d_o), int'(exp_q[0].data));
                check("depth_o", int'(depth_o), exp_depth);
                check("cfg_ready_o", int'(cfg_ready_o),
                      int'(!en_i && !flush_i && inflight == 0));
                check("cnt_o", int'(cnt_o), exp_cnt);
                if (exp_v && (en_i || flush_i)) begin
                    $display("beat %h out at advance %0d depth %0d", exp_q[0].data, cur_n, exp_depth);
                    void'(exp_q.pop_front());
                end
                if (flush_i) exp_q.delete();
            end
        end
    end

    // Stimulus
    initial begin
        // Reset state
        @(negedge clk_i);
        check("reset_valid_o", int'(valid_o), 0);
        check("reset_d_o", int'(d_o), 0);
        check("reset_depth_o", int'(depth_o), RD);
        check("reset_cnt_o", int'(cnt_o), 0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;

        // Three back-to-back beats at depth 3
        drive(1, 0, 1, 16'h00A0, 0, 0);
        drive(1, 0, 1, 16'h00A1, 0, 0);
        drive(1, 0, 1, 16'h00A2, 0, 0);
        bubbles(5);

        // Stall for two cycles after the first beat enters
        drive(1, 0, 1, 16'h00A0, 0, 0);
        drive(0, 0, 1, 16'h0EEE, 0, 0);
        drive(0, 0, 0, '0, 0, 0);
        drive(1, 0, 1, 16'h00A1, 0, 0);
        drive(1, 0, 1, 16'h00A2, 0, 0);
        bubbles(5);

        // Flush with two beats in flight and a beat offered in the flush cycle
        drive(1, 0, 1, 16'h00B0, 0, 0);
        drive(1, 0, 1, 16'h00B1, 0, 0);
        drive(1, 1, 1, 16'h00BB, 0, 0);
        bubbles(5);

        // Pass-through, saturation, and a refused request
        set_depth(0);
        drive(1, 0, 1, 16'h00C0, 0, 0);
        drive(0, 0, 1, 16'h00C1, 0, 0);
        drive(1, 0, 0, 16'h00C2, 0, 0);
        set_depth(12);
        drive(1, 0, 1, 16'h00D0, 0, 0);
        drive(0, 0, 0, '0, 1, 2);
        drive(0, 0, 0, '0, 1, 2);
        bubbles(MD + 2);

        // Occupancy profile at depth 4
        set_depth(4);
        drive(1, 0, 1, 16'h00E0, 0, 0);
        drive(1, 0, 1, 16'h00E1, 0, 0);
        drive(1, 0, 1, 16'h00E2, 0, 0);
        bubbles(6);

        // Reset in the middle of a stream
        drive(1, 0, 1, 16'h00F0, 0, 0);
        drive(1, 0, 1, 16'h00F1, 0, 0);
        do_reset();
        bubbles(5);

        // Randomized rounds
        for (int r = 0; r < 25; r++) begin
            set_depth($urandom_range(0, 12));
            for (int c = 0; c < 30; c++) begin
                drive($urandom_range(0, 3) != 0,
                      $urandom_range(0, 19) == 0,
                      $urandom_range(0, 2) != 0,
                      DW'($urandom),
                      $urandom_range(0, 7) == 0,
                      $urandom_range(0, 12));
            end
            bubbles(MD + 2);
        end

        @(negedge clk_i);
        check("drain_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
